nor_gate: RTL and testbench

- Bitwise two-input NOR primitive for the basic-gate library.
- Provides a zero-latency combinational result, plus a registered copy and a saturating "all-ones result" event counter for pipelined consumers and self-checking benches.
- Single clock domain; sits at leaf level under any datapath needing inverted-OR logic.

---
 rtl/nor_gate.sv | 58 +++++
 tb/tb_nor_gate.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/nor_gate.sv
// Bitwise two-input NOR with a zero-latency result, a registered copy and a
// saturating counter of enabled cycles whose result is all ones.
module nor_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic [WIDTH-1:0] F_o,
    output logic [WIDTH-1:0] F_r_o,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic             hit_sat_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [WIDTH-1:0] fReg_q;
    logic [WIDTH-1:0] fReg_d;
    logic [CNT_W-1:0] hitCnt_q;
    logic [CNT_W-1:0] hitCnt_d;
    logic             allOnes;

    assign F_o     = ~(A_i | B_i);
    assign allOnes = &F_o;

    // Clear beats increment; the counter sticks at its maximum instead of wrapping.
    always_comb begin
        fReg_d   = fReg_q;
        hitCnt_d = hitCnt_q;
        if (en_i) begin
            fReg_d = F_o;
        end
        if (clr_i) begin
            hitCnt_d = '0;
        end else if (en_i && allOnes && (hitCnt_q != CntMax)) begin
            hitCnt_d = hitCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fReg_q   <= '0;
            hitCnt_q <= '0;
        end else begin
            fReg_q   <= fReg_d;
            hitCnt_q <= hitCnt_d;
        end
    end

    assign F_r_o     = fReg_q;
    assign hit_cnt_o = hitCnt_q;
    assign hit_sat_o = (hitCnt_q == CntMax);

endmodule

// File: tb/tb_nor_gate.sv
// Directed bench for nor_gate: a 1-bit and a 4-bit instance, both with a
// 2-bit counter so saturation is reached within a handful of edges.
module tb_nor_gate;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       a1, b1;
    logic [3:0] a4, b4;
    logic       f1, fr1;
    logic [3:0] f4, fr4;
    logic [1:0] cnt1, cnt4;
    logic       sat1, sat4;

    int compared   = 0;
    int mismatched = 0;

    nor_gate #(.WIDTH(1), .CNT_W(2)) u_dut1 (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (en),
        .clr_i    (clr),
        .A_i      (a1),
        .B_i      (b1),
        .F_o      (f1),
        .F_r_o    (fr1),
        .hit_cnt_o(cnt1),
        .hit_sat_o(sat1)
    );

    nor_gate #(.WIDTH(4), .CNT_W(2)) u_dut4 (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (en),
        .clr_i    (clr),
        .A_i      (a4),
        .B_i      (b4),
        .F_o      (f4),
        .F_r_o    (fr4),
        .hit_cnt_o(cnt4),
        .hit_sat_o(sat4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic applyStimulus;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;

        // Combinational truth table, valid even while in reset
        #5; checkOutput("tt00", 32'(f1), 32'h1);
        a1 = 1'b1; b1 = 1'b0;
        #5; checkOutput("tt10", 32'(f1), 32'h0);
        a1 = 1'b0; b1 = 1'b1;
        #5; checkOutput("tt01", 32'(f1), 32'h0);
        a1 = 1'b1; b1 = 1'b1;
        #5; checkOutput("tt11", 32'(f1), 32'h0);

        // Reset for two edges with all-zero operands
        a1 = 1'b0; b1 = 1'b0;
        applyStimulus;
        checkOutput("rst1_f1", 32'(f1), 32'h1);
        applyStimulus;
        checkOutput("rst_fr1",  32'(fr1),  32'h0);
        checkOutput("rst_cnt1", 32'(cnt1), 32'h0);
        checkOutput("rst_sat1", 32'(sat1), 32'h0);
        checkOutput("rst_f1",   32'(f1),   32'h1);
        checkOutput("rst_fr4",  32'(fr4),  32'h0);
        checkOutput("rst_cnt4", 32'(cnt4), 32'h0);
        checkOutput("rst_f4",   32'(f4),   32'hF);

        // Registered latency and hold when disabled
        rst = 1'b0;
        applyStimulus;
        checkOutput("lat1_fr1",  32'(fr1),  32'h1);
        checkOutput("lat1_cnt1", 32'(cnt1), 32'h1);
        a1 = 1'b1; a4 = 4'b0001;
        applyStimulus;
        checkOutput("lat2_fr1",  32'(fr1),  32'h0);
        checkOutput("lat2_cnt1", 32'(cnt1), 32'h1);
        checkOutput("lat2_fr4",  32'(fr4),  32'hE);
        checkOutput("lat2_cnt4", 32'(cnt4), 32'h1);
        en = 1'b0; a1 = 1'b0; a4 = 4'h0;
        applyStimulus;
        checkOutput("hold_fr1",  32'(fr1),  32'h0);
        checkOutput("hold_cnt1", 32'(cnt1), 32'h1);
        checkOutput("hold_fr4",  32'(fr4),  32'hE);

        // Clear while disabled, then count up to saturation
        clr = 1'b1;
        applyStimulus;
        checkOutput("clr_en0_cnt1", 32'(cnt1), 32'h0);
        checkOutput("clr_en0_cnt4", 32'(cnt4), 32'h0);
        clr = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus;
            checkOutput($sformatf("cnt1_e%0d", i), 32'(cnt1), (i < 2) ? 32'(i + 1) : 32'h3);
            checkOutput($sformatf("sat1_e%0d", i), 32'(sat1), (i < 2) ? 32'h0 : 32'h1);
            checkOutput($sformatf("cnt4_e%0d", i), 32'(cnt4), (i < 2) ? 32'(i + 1) : 32'h3);
            checkOutput($sformatf("sat4_e%0d", i), 32'(sat4), (i < 2) ? 32'h0 : 32'h1);
        end

        // Clear beats increment
        clr = 1'b1;
        applyStimulus;
        checkOutput("clr_cnt1", 32'(cnt1), 32'h0);
        checkOutput("clr_sat1", 32'(sat1), 32'h0);
        checkOutput("clr_fr1",  32'(fr1),  32'h1);
        clr = 1'b0;
        applyStimulus;
        checkOutput("post_clr_cnt1", 32'(cnt1), 32'h1);

        // Reset beats enable mid-operation
        rst = 1'b1;
        applyStimulus;
        checkOutput("rst2_fr1",  32'(fr1),  32'h0);
        checkOutput("rst2_cnt1", 32'(cnt1), 32'h0);
        checkOutput("rst2_sat1", 32'(sat1), 32'h0);
        checkOutput("rst2_fr4",  32'(fr4),  32'h0);
        checkOutput("rst2_f1",   32'(f1),   32'h1);
        rst = 1'b0;

        // Multi-bit: partial ones must not count
        a4 = 4'b0011; b4 = 4'b0101;
        #1; checkOutput("mb_f4", 32'(f4), 32'h8);
        applyStimulus;
        checkOutput("mb_cnt4", 32'(cnt4), 32'h0);
        checkOutput("mb_fr4",  32'(fr4),  32'h8);
        a4 = 4'h0; b4 = 4'h0;
        #1; checkOutput("mb0_f4", 32'(f4), 32'hF);
        applyStimulus;
        checkOutput("mb0_cnt4", 32'(cnt4), 32'h1);
        checkOutput("mb0_fr4",  32'(fr4),  32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
